// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment display sniffer.
//   - Segment bit indices within the 8-bit segments bus (a..g, dp).
//   - Hex glyph table in gfedcba order, indexed by nibble value.
//   - Filter FSM state encoding.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  localparam int unsigned NumDigits = 4;

  // Glyph for nibble i lives at index i.
  localparam logic [6:0] HEX_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StHeld
  } filt_state_e;

endpackage

// File: rtl/seg7_mux_decoder_if.sv
// Bundle of the multiplexed display pins and the decoded result.
//   segments : bit0..6 = seg a..g, bit7 = dp (raw pins)
//   digits   : digit selects, bit3 = leftmost digit (raw pins)
//   hexx     : decoded nibbles, [15:12] = digit3 ... [3:0] = digit0
//   points   : latched dp per digit
//   blank    : digit last seen with a..g all off
//   err      : digit last seen with a non-hex glyph
//   valid    : digit latched recently
//   update   : one-cycle pulse on any change of the latched state
// master = the side driving the display pins; slave = the decoder.
interface seg7_mux_decoder_if;
  logic [7:0]  segments;
  logic [3:0]  digits;
  logic [15:0] hexx;
  logic [3:0]  points;
  logic [3:0]  blank;
  logic [3:0]  err;
  logic [3:0]  valid;
  logic        update;

  modport master (
    output segments, digits,
    input  hexx, points, blank, err, valid, update
  );

  modport slave (
    input  segments, digits,
    output hexx, points, blank, err, valid, update
  );
endinterface

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup of a 7-bit segment glyph.
//   pat_i    : normalised segments a..g (1 = lit)
//   nibble_o : table index when hit_o is set, else 0
//   hit_o    : glyph is one of the 16 hex glyphs
//   blank_o  : all segments off
module seg7_pattern_lookup
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       hit_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = 4'd0;
    hit_o    = 1'b0;
    // Table entries are distinct, so at most one index matches.
    for (int i = 0; i < 16; i++) begin
      if (pat_i == HEX_TABLE[i]) begin
        nibble_o = 4'(i);
        hit_o    = 1'b1;
      end
    end
    blank_o = (pat_i == 7'h00);
  end

endmodule

// File: rtl/seg7_mux_decoder.sv
// Receive side of a multiplexed 4-digit 7-segment bus. Synchronises the
// raw pins, rejects multiplex/PWM glitches with a stability filter and
// rebuilds per-digit hex value, dp, blank, error and valid state.
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg7_mux_decoder_if.slave (pins in, decoded state out)
module seg7_mux_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter bit          SEG_ACTIVE_HIGH = 1'b1,
  parameter bit          DIG_ACTIVE_LOW  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  seg7_mux_decoder_if.slave bus
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYCLES);
  // Reset the digit synchroniser to "nothing selected".
  localparam logic [3:0] DigIdle = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  // ---------------------------------------------------------------------
  // Input synchronisers
  // ---------------------------------------------------------------------
  logic [7:0] seg_s1_d, seg_s1_q, seg_s2_d, seg_s2_q;
  logic [3:0] dig_s1_d, dig_s1_q, dig_s2_d, dig_s2_q;

  always_comb begin
    seg_s1_d = bus.segments;
    seg_s2_d = seg_s1_q;
    dig_s1_d = bus.digits;
    dig_s2_d = dig_s1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dig_s1_q <= DigIdle;
      dig_s2_q <= DigIdle;
    end else begin
      seg_s1_q <= seg_s1_d;
      seg_s2_q <= seg_s2_d;
      dig_s1_q <= dig_s1_d;
      dig_s2_q <= dig_s2_d;
    end
  end

  // Normalised: segment bit = 1 when lit, digit bit = 1 when selected.
  logic [7:0] seg_n;
  logic [3:0] dig_n;
  logic       one_hot;
  logic [1:0] dig_idx;

  always_comb begin
    seg_n   = SEG_ACTIVE_HIGH ? seg_s2_q : ~seg_s2_q;
    dig_n   = DIG_ACTIVE_LOW ? ~dig_s2_q : dig_s2_q;
    one_hot = (dig_n != 4'd0) && ((dig_n & (dig_n - 4'd1)) == 4'd0);
    dig_idx = 2'd0;
    case (dig_n)
      4'b0010: dig_idx = 2'd1;
      4'b0100: dig_idx = 2'd2;
      4'b1000: dig_idx = 2'd3;
      default: dig_idx = 2'd0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Stability filter FSM
  // ---------------------------------------------------------------------
  filt_state_e     state_d, state_q;
  logic [1:0]      cur_dig_d, cur_dig_q;
  logic [7:0]      cur_pat_d, cur_pat_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            same;
  logic            latch_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_dig_d = cur_dig_q;
    cur_pat_d = cur_pat_q;
    cnt_d     = cnt_q;
    same      = one_hot && (dig_idx == cur_dig_q) && (seg_n == cur_pat_q);
    if (!one_hot) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else if ((state_q == StIdle) || !same) begin
      cur_dig_d = dig_idx;
      cur_pat_d = seg_n;
      cnt_d     = CntW'(1);
      state_d   = (STABLE_CYCLES == 1) ? StHeld : StCount;
    end else if (state_q == StCount) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_d == CntMax) begin
        state_d = StHeld;
      end
    end
  end

  // Fire on every arrival in HELD, including a reload straight into HELD
  // when only one sample is needed; a repeat of the held sample is silent.
  always_comb begin
    latch_fire = one_hot && (state_d == StHeld) && ((state_q != StHeld) || !same);
  end

  // Latch request is registered, so outputs move one cycle later.
  logic       lat_vld_d, lat_vld_q;
  logic [1:0] lat_dig_d, lat_dig_q;
  logic [7:0] lat_pat_d, lat_pat_q;

  always_comb begin
    lat_vld_d = latch_fire;
    lat_dig_d = latch_fire ? cur_dig_d : lat_dig_q;
    lat_pat_d = latch_fire ? cur_pat_d : lat_pat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_dig_q <= '0;
      cur_pat_q <= '0;
      cnt_q     <= '0;
      lat_vld_q <= 1'b0;
      lat_dig_q <= '0;
      lat_pat_q <= '0;
    end else begin
      cur_dig_q <= cur_dig_d;
      cur_pat_q <= cur_pat_d;
      cnt_q     <= cnt_d;
      lat_vld_q <= lat_vld_d;
      lat_dig_q <= lat_dig_d;
      lat_pat_q <= lat_pat_d;
    end
  end

  // ---------------------------------------------------------------------
  // Glyph lookup
  // ---------------------------------------------------------------------
  logic [3:0] lk_nibble;
  logic       lk_hit;
  logic       lk_blank;

  seg7_pattern_lookup u_lookup (
    .pat_i    (lat_pat_q[6:0]),
    .nibble_o (lk_nibble),
    .hit_o    (lk_hit),
    .blank_o  (lk_blank)
  );

  // ---------------------------------------------------------------------
  // Per-digit state and timeouts
  // ---------------------------------------------------------------------
  logic [15:0]     hexx_d, hexx_q;
  logic [3:0]      points_d, points_q;
  logic [3:0]      blank_d, blank_q;
  logic [3:0]      err_d, err_q;
  logic [3:0]      valid_d, valid_q;
  logic            update_d, update_q;
  logic [TmoW-1:0] tmo_d [NumDigits];
  logic [TmoW-1:0] tmo_q [NumDigits];
  logic [3:0]      expire;

  always_comb begin
    hexx_d   = hexx_q;
    points_d = points_q;
    blank_d  = blank_q;
    err_d    = err_q;
    valid_d  = valid_q;
    expire   = '0;

    for (int d = 0; d < NumDigits; d++) begin
      tmo_d[d] = (tmo_q[d] == TmoMax) ? tmo_q[d] : tmo_q[d] + TmoW'(1);
      // Counter reaches the limit on this edge.
      if (valid_q[d] && (tmo_q[d] == TmoMax - TmoW'(1))) begin
        expire[d] = 1'b1;
      end
    end

    // A latch on the expiring digit wins.
    if (lat_vld_q) begin
      expire[lat_dig_q] = 1'b0;
      tmo_d[lat_dig_q]  = '0;
    end

    for (int d = 0; d < NumDigits; d++) begin
      if (expire[d]) begin
        valid_d[d] = 1'b0;
      end
    end

    if (lat_vld_q) begin
      points_d[lat_dig_q] = lat_pat_q[SEG_DP];
      valid_d[lat_dig_q]  = 1'b1;
      if (lk_blank) begin
        blank_d[lat_dig_q] = 1'b1;
        err_d[lat_dig_q]   = 1'b0;
      end else if (lk_hit) begin
        hexx_d[{lat_dig_q, 2'b00} +: 4] = lk_nibble;
        blank_d[lat_dig_q]              = 1'b0;
        err_d[lat_dig_q]                = 1'b0;
      end else begin
        blank_d[lat_dig_q] = 1'b0;
        err_d[lat_dig_q]   = 1'b1;
      end
    end

    // One pulse covers any mix of latch change and expiries.
    update_d = {hexx_d, points_d, blank_d, err_d, valid_d} !=
               {hexx_q, points_q, blank_q, err_q, valid_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hexx_q   <= '0;
      points_q <= '0;
      blank_q  <= 4'hF;
      err_q    <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      for (int d = 0; d < NumDigits; d++) begin
        tmo_q[d] <= '0;
      end
    end else begin
      hexx_q   <= hexx_d;
      points_q <= points_d;
      blank_q  <= blank_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      for (int d = 0; d < NumDigits; d++) begin
        tmo_q[d] <= tmo_d[d];
      end
    end
  end

  assign bus.hexx   = hexx_q;
  assign bus.points = points_q;
  assign bus.blank  = blank_q;
  assign bus.err    = err_q;
  assign bus.valid  = valid_q;
  assign bus.update = update_q;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Directed bench for seg7_mux_decoder. Stimulus pushes the expected
// update event (cycle + full output state) into a queue; a monitor pops
// and compares on every update pulse, and flags missing or extra pulses.
module tb_seg7_mux_decoder;

  localparam int unsigned Stable = 4;
  localparam int unsigned Tmo    = 4096;
  localparam int          Lat    = 2 + Stable + 1;

  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;
  localparam logic [3:0] DNone = 4'b1111;

  typedef struct {
    int          cyc;
    logic [31:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic [7:0] pat_cur [4];

  seg7_mux_decoder_if bus ();

  seg7_mux_decoder #(
    .STABLE_CYCLES   (Stable),
    .TIMEOUT_CYCLES  (Tmo),
    .SEG_ACTIVE_HIGH (1'b1),
    .DIG_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] cur_st();
    return {bus.hexx, bus.points, bus.blank, bus.err, bus.valid};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [3:0] dig, input logic [7:0] seg);
    bus.digits   = dig;
    bus.segments = seg;
  endtask

  // Hold one strobe for n cycles, then 2 idle cycles.
  task automatic show(input logic [3:0] dig, input logic [7:0] seg, input int n);
    drive(dig, seg);
    tick(n);
    drive(DNone, 8'h00);
    tick(2);
  endtask

  task automatic expect_evt(input int c, input logic [15:0] h, input logic [3:0] p,
                            input logic [3:0] b, input logic [3:0] e, input logic [3:0] v);
    exp_t x;
    x.cyc = c;
    x.st  = {h, p, b, e, v};
    sb.push_back(x);
  endtask

  // One scan over the digits selected in mask, 8 cycles each.
  task automatic show_round(input logic [3:0] mask);
    if (mask[0]) show(D0, pat_cur[0], 8);
    if (mask[1]) show(D1, pat_cur[1], 8);
    if (mask[2]) show(D2, pat_cur[2], 8);
    if (mask[3]) show(D3, pat_cur[3], 8);
  endtask

  // Monitor: compare every update pulse against the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.update) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_update: got pulse at cycle %0d want none", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("update_cycle", 64'(cyc), 64'(e.cyc));
          chk("update_state", 64'(cur_st()), 64'(e.st));
        end
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_update: got none by cycle %0d want pulse at %0d",
                 cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int s;
    int r;
    pat_cur[0] = 8'h71;
    pat_cur[1] = 8'h4F;
    pat_cur[2] = 8'h77;
    pat_cur[3] = 8'h86;

    drive(DNone, 8'h00);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("reset_state", 64'(cur_st()), 64'({16'h0000, 4'h0, 4'hF, 4'h0, 4'h0}));
    chk("reset_update", 64'(bus.update), 64'd0);

    // Single digit, first latch latency.
    s = cyc;
    expect_evt(s + Lat, 16'h0001, 4'h0, 4'b1110, 4'h0, 4'b0001);
    show(D0, 8'h06, 6);
    tick(4);

    // Round-robin 0x1A3F, dp on digit3.
    s = cyc;
    expect_evt(s + Lat, 16'h000F, 4'h0, 4'b1110, 4'h0, 4'b0001);
    show(D0, 8'h71, 8);
    s = cyc;
    expect_evt(s + Lat, 16'h003F, 4'h0, 4'b1100, 4'h0, 4'b0011);
    show(D1, 8'h4F, 8);
    s = cyc;
    expect_evt(s + Lat, 16'h0A3F, 4'h0, 4'b1000, 4'h0, 4'b0111);
    show(D2, 8'h77, 8);
    s = cyc;
    expect_evt(s + Lat, 16'h1A3F, 4'b1000, 4'b0000, 4'h0, 4'hF);
    show(D3, 8'h86, 8);
    show_round(4'hF);
    show_round(4'hF);
    chk("scan_state", 64'(cur_st()), 64'({16'h1A3F, 4'b1000, 4'h0, 4'h0, 4'hF}));

    // Glitches: short strobe, then multi-hot selects.
    show(D0, 8'h06, 3);
    show(4'b1100, 8'h06, 10);
    tick(10);
    chk("glitch_state", 64'(cur_st()), 64'({16'h1A3F, 4'b1000, 4'h0, 4'h0, 4'hF}));

    // Non-hex glyph on digit2, then blank.
    pat_cur[2] = 8'h49;
    s = cyc;
    expect_evt(s + Lat, 16'h1A3F, 4'b1000, 4'b0000, 4'b0100, 4'hF);
    show(D2, 8'h49, 8);
    pat_cur[2] = 8'h00;
    s = cyc;
    expect_evt(s + Lat, 16'h1A3F, 4'b1000, 4'b0100, 4'b0000, 4'hF);
    show(D2, 8'h00, 8);

    // Digit1 last latch, then keep scanning only 0, 2, 3.
    s = cyc;
    expect_evt(s + Lat + Tmo, 16'h1A3F, 4'b1000, 4'b0100, 4'b0000, 4'b1101);
    show(D1, 8'h4F, 8);
    while (cyc < s + Lat + Tmo + 40) show_round(4'b1101);
    chk("timeout_state", 64'(cur_st()), 64'({16'h1A3F, 4'b1000, 4'b0100, 4'h0, 4'b1101}));

    // Reset during COUNT, then resume the same strobe.
    drive(D0, 8'h66);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    chk("midreset_state", 64'(cur_st()), 64'({16'h0000, 4'h0, 4'hF, 4'h0, 4'h0}));
    rst_n = 1'b1;
    r = cyc;
    expect_evt(r + Lat, 16'h0004, 4'h0, 4'b1110, 4'h0, 4'b0001);
    tick(3);
    chk("resume_early", 64'(cur_st()), 64'({16'h0000, 4'h0, 4'hF, 4'h0, 4'h0}));
    tick(3);
    chk("resume_before", 64'(cur_st()), 64'({16'h0000, 4'h0, 4'hF, 4'h0, 4'h0}));
    tick(4);
    drive(DNone, 8'h00);
    tick(10);
    chk("resume_after", 64'(cur_st()), 64'({16'h0004, 4'h0, 4'b1110, 4'h0, 4'b0001}));

    tick(5);
    chk("pending_events", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
